frame_peak_tracker: RTL

- Downstream consumer of the team's 8-bit magnitude comparator (a_high / b_high / equal flags).
- Accepts a stream of unsigned 8-bit samples, grouped into frames of FRAME_LEN samples.
- Per frame it tracks the running maximum and minimum, and counts how many samples hit each.
- Presents one result per frame on a valid/ready output port.

---
 rtl/frame_peak_pkg.sv | 13 +
 rtl/frame_peak_tracker_if.sv | 28 ++
 rtl/peak_cmp_unit.sv | 49 ++++
 rtl/frame_peak_tracker.sv | 125 ++++++++++++
 4 files changed

// File: rtl/frame_peak_pkg.sv
// Shared definitions for the frame peak tracker: FSM state encoding and default sizes.
package frame_peak_pkg;

  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/frame_peak_tracker_if.sv
// Sample-in / result-out handshake bundle of the frame peak tracker.
interface frame_peak_tracker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic [CNT_W-1:0]  out_max_cnt;
  logic [CNT_W-1:0]  out_min_cnt;
  logic              busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_cnt, out_min_cnt, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_cnt, out_min_cnt, busy
  );

endinterface

// File: rtl/peak_cmp_unit.sv
// Combinational sample-vs-extremes compare built from two 8-bit magnitude comparators.
module mag_comp8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       a_high_o,
  output logic       b_high_o,
  output logic       equal_o
);

  assign a_high_o = (a_i > b_i);
  assign b_high_o = (a_i < b_i);
  assign equal_o  = (a_i == b_i);

endmodule

module peak_cmp_unit (
  input  logic [7:0] sample_i,
  input  logic [7:0] cur_max_i,
  input  logic [7:0] cur_min_i,
  output logic       gt_max_o,
  output logic       eq_max_o,
  output logic       lt_min_o,
  output logic       eq_min_o
);

  logic max_b_high;
  logic min_a_high;

  mag_comp8 u_cmp_max (
    .a_i      (sample_i),
    .b_i      (cur_max_i),
    .a_high_o (gt_max_o),
    .b_high_o (max_b_high),
    .equal_o  (eq_max_o)
  );

  // The sample is operand a in both compares, so "below min" is the b_high flag.
  mag_comp8 u_cmp_min (
    .a_i      (sample_i),
    .b_i      (cur_min_i),
    .a_high_o (min_a_high),
    .b_high_o (lt_min_o),
    .equal_o  (eq_min_o)
  );

  logic unused_flags;
  assign unused_flags = max_b_high ^ min_a_high;

endmodule

// File: rtl/frame_peak_tracker.sv
// Per-frame running max/min tracker with hit counts; one result per frame on a valid/ready port.
module frame_peak_tracker
  import frame_peak_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_peak_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]  max_cnt_q, max_cnt_d;
  logic [CNT_W-1:0]  min_cnt_q, min_cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;

  logic in_ready;
  logic xfer;
  logic gt_max, eq_max, lt_min, eq_min;

  assign in_ready = ~rst & (state_q != ST_HOLD);
  assign xfer     = bus.in_valid & in_ready;

  peak_cmp_unit u_cmp (
    .sample_i  (bus.in_data),
    .cur_max_i (max_q),
    .cur_min_i (min_q),
    .gt_max_o  (gt_max),
    .eq_max_o  (eq_max),
    .lt_min_o  (lt_min),
    .eq_min_o  (eq_min)
  );

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_cnt_d = max_cnt_q;
    min_cnt_d = min_cnt_q;
    idx_d     = idx_q;
    busy_d    = busy_q;

    case (state_q)
      ST_FIRST: begin
        if (xfer) begin
          max_d     = bus.in_data;
          min_d     = bus.in_data;
          max_cnt_d = ONE;
          min_cnt_d = ONE;
          idx_d     = ONE;
          busy_d    = 1'b1;
          state_d   = (FRAME_LEN == 1) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          // Max and min are updated independently; an equal sample can bump both counts.
          if (gt_max) begin
            max_d     = bus.in_data;
            max_cnt_d = ONE;
          end else if (eq_max) begin
            max_cnt_d = max_cnt_q + ONE;
          end
          if (lt_min) begin
            min_d     = bus.in_data;
            min_cnt_d = ONE;
          end else if (eq_min) begin
            min_cnt_d = min_cnt_q + ONE;
          end
          idx_d = idx_q + ONE;
          if (idx_q + ONE == LAST_IDX) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_FIRST;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FIRST;
      max_q     <= '0;
      min_q     <= '0;
      max_cnt_q <= '0;
      min_cnt_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_cnt_q <= max_cnt_d;
      min_cnt_q <= min_cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == ST_HOLD);
  assign bus.out_max     = max_q;
  assign bus.out_min     = min_q;
  assign bus.out_max_cnt = max_cnt_q;
  assign bus.out_min_cnt = min_cnt_q;
  assign bus.busy        = busy_q;

endmodule
